// File: rtl/dot_vector_packer.sv
// rtl/dot_vector_packer.sv - packs a stream of (a,b) element pairs into 4-lane vectors
//
// Optional feature macro: VEC_PAD_EN (in_last closes a vector early, upper lanes zero-filled).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active low
//   in_valid   in   input pair valid
//   in_ready   out  pair can be accepted this cycle
//   in_a       in   element of vector a (DATA_WIDTH)
//   in_b       in   element of vector b (DATA_WIDTH)
//   in_last    in   pair closes the vector early (VEC_PAD_EN only)
//   out_valid  out  packed vector valid
//   out_ready  in   consumer accepts vector
//   out_a      out  packed vector a, lane 0 in the low bits (4*DATA_WIDTH)
//   out_b      out  packed vector b, lane 0 in the low bits (4*DATA_WIDTH)
//   vec_count  out  vectors consumed since reset, wrapping (CNT_WIDTH)

module dot_vector_packer #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_a,
   input  logic [DATA_WIDTH-1:0]     in_b,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [4*DATA_WIDTH-1:0]   out_a,
   output logic [4*DATA_WIDTH-1:0]   out_b,
   output logic [CNT_WIDTH-1:0]      vec_count
);

   logic [1:0]            fill_cnt;
   logic [DATA_WIDTH-1:0] lane_a [0:2];
   logic [DATA_WIDTH-1:0] lane_b [0:2];

   logic                  accept;
   logic                  close;
   logic [4*DATA_WIDTH-1:0] next_a;
   logic [4*DATA_WIDTH-1:0] next_b;

   assign accept = in_valid & in_ready;

`ifdef VEC_PAD_EN
   // Every lane stalls while the output is blocked, because any pair may close a vector.
   assign in_ready = ~out_valid | out_ready;
   assign close    = accept & ((fill_cnt == 2'd3) | in_last);
`else
   // Only the closing lane needs the output register; lanes 0..2 keep filling under backpressure.
   assign in_ready = (fill_cnt != 2'd3) | ~out_valid | out_ready;
   assign close    = accept & (fill_cnt == 2'd3);
   logic unused_last;
   assign unused_last = in_last;
`endif

   // Closing vector: stored lanes below fill_cnt, the incoming pair at fill_cnt, zeros above.
   always_comb begin
      next_a = '0;
      next_b = '0;
      for (int i = 0; i < 3; i++) begin
         if (2'(i) < fill_cnt) begin
            next_a[i*DATA_WIDTH +: DATA_WIDTH] = lane_a[i];
            next_b[i*DATA_WIDTH +: DATA_WIDTH] = lane_b[i];
         end
      end
      next_a[int'(fill_cnt)*DATA_WIDTH +: DATA_WIDTH] = in_a;
      next_b[int'(fill_cnt)*DATA_WIDTH +: DATA_WIDTH] = in_b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt  <= 2'd0;
         out_valid <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
         vec_count <= '0;
         for (int i = 0; i < 3; i++) begin
            lane_a[i] <= '0;
            lane_b[i] <= '0;
         end
      end else begin
         if (accept && !close) begin
            for (int i = 0; i < 3; i++) begin
               if (fill_cnt == 2'(i)) begin
                  lane_a[i] <= in_a;
                  lane_b[i] <= in_b;
               end
            end
            fill_cnt <= fill_cnt + 2'd1;
         end

         // A closing pair reloads the output in the same cycle it is consumed, so no bubble.
         if (close) begin
            out_a     <= next_a;
            out_b     <= next_b;
            out_valid <= 1'b1;
            fill_cnt  <= 2'd0;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (out_valid && out_ready) begin
            vec_count <= vec_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dot_vector_packer.sv
// tb/tb_dot_vector_packer.sv - directed-vector bench for dot_vector_packer

module tb_dot_vector_packer;

   localparam int DW = 32;
   localparam int CW = 8;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_a;
   logic [DW-1:0]     in_b;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [4*DW-1:0]   out_a;
   logic [4*DW-1:0]   out_b;
   logic [CW-1:0]     vec_count;

   int vec_applied = 0;
   int miscompares = 0;
   int cyc = 0;

   dot_vector_packer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .vec_count (vec_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vec_applied++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Presents one pair at a negedge and returns at the negedge after it was accepted.
   task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
      int n;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_eq("push_timeout", 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      int t1;
      int t2;
      logic [127:0] exp_v;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      // 1: reset state and first vector latency
      apply_reset();
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_out_a", out_a, 128'h0);
      check_eq("rst_out_b", out_b, 128'h0);
      check_eq("rst_vec_count", vec_count, 8'd0);
      check_eq("rst_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      push(32'h3F800000, 32'h3F800000, 1'b0);
      push(32'h40000000, 32'h3F800000, 1'b0);
      push(32'h40400000, 32'h3F800000, 1'b0);
      check_eq("t1_not_yet_valid", out_valid, 1'b0);
      push(32'h40800000, 32'h3F800000, 1'b0);
      check_eq("t1_out_valid", out_valid, 1'b1);
      check_eq("t1_out_a", out_a, 128'h40800000_40400000_40000000_3F800000);
      check_eq("t1_out_b", out_b, 128'h3F800000_3F800000_3F800000_3F800000);
      @(negedge clk);
      check_eq("t1_consumed", out_valid, 1'b0);
      check_eq("t1_vec_count", vec_count, 8'd1);

      // 2: back-to-back, two vectors exactly 4 cycles apart
      apply_reset();
      out_ready = 1'b1;
      t1 = 0;
      t2 = 0;
      for (int i = 0; i < 8; i++) begin
         check_eq("t2_in_ready", in_ready, 1'b1);
         push(32'h1000 + 32'(i), 32'h2000 + 32'(i), 1'b0);
         if (i == 3) t1 = cyc;
         if (i == 7) t2 = cyc;
      end
      check_eq("t2_out_valid", out_valid, 1'b1);
      check_eq("t2_out_a", out_a, 128'h00001007_00001006_00001005_00001004);
      check_eq("t2_out_b", out_b, 128'h00002007_00002006_00002005_00002004);
      check_eq("t2_spacing", 32'(t2 - t1), 32'd4);
      @(negedge clk);
      check_eq("t2_vec_count", vec_count, 8'd2);

      // 3: backpressure
      apply_reset();
      out_ready = 1'b0;
      push(32'hA0, 32'hC0, 1'b0);
      push(32'hA1, 32'hC1, 1'b0);
      push(32'hA2, 32'hC2, 1'b0);
      push(32'hA3, 32'hC3, 1'b0);
      check_eq("t3_v1_valid", out_valid, 1'b1);
`ifdef VEC_PAD_EN
      in_valid = 1'b1;
      in_a     = 32'hB0;
      in_b     = 32'hD0;
      check_eq("t3_pad_stall", in_ready, 1'b0);
      @(negedge clk);
      check_eq("t3_pad_hold_a", out_a, 128'h000000A3_000000A2_000000A1_000000A0);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("t3_pad_drained", out_valid, 1'b0);
      check_eq("t3_pad_vec_count", vec_count, 8'd1);
`else
      push(32'hB0, 32'hD0, 1'b0);
      push(32'hB1, 32'hD1, 1'b0);
      push(32'hB2, 32'hD2, 1'b0);
      check_eq("t3_hold_a", out_a, 128'h000000A3_000000A2_000000A1_000000A0);
      in_valid = 1'b1;
      in_a     = 32'hB3;
      in_b     = 32'hD3;
      check_eq("t3_stall", in_ready, 1'b0);
      @(negedge clk);
      check_eq("t3_stall2", in_ready, 1'b0);
      check_eq("t3_hold_a2", out_a, 128'h000000A3_000000A2_000000A1_000000A0);
      check_eq("t3_hold_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      #1;
      check_eq("t3_release", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("t3_v2_valid", out_valid, 1'b1);
      check_eq("t3_v2_a", out_a, 128'h000000B3_000000B2_000000B1_000000B0);
      check_eq("t3_v2_b", out_b, 128'h000000D3_000000D2_000000D1_000000D0);
      check_eq("t3_vec_count", vec_count, 8'd1);
`endif

      // 4: reset mid-vector discards partial lanes
      apply_reset();
      out_ready = 1'b1;
      push(32'hDEAD0000, 32'hBEEF0000, 1'b0);
      push(32'hDEAD0001, 32'hBEEF0001, 1'b0);
      rst_n = 1'b0;
      #1;
      check_eq("t4_async_rst_count", vec_count, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(32'h11, 32'h21, 1'b0);
      push(32'h12, 32'h22, 1'b0);
      push(32'h13, 32'h23, 1'b0);
      push(32'h14, 32'h24, 1'b0);
      check_eq("t4_out_a", out_a, 128'h00000014_00000013_00000012_00000011);
      @(negedge clk);
      check_eq("t4_vec_count", vec_count, 8'd1);

      // 5: vec_count wrap
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4 * (1 << CW); i++) push(32'(i), 32'(i), 1'b0);
      check_eq("t5_pre_wrap", vec_count, 8'd255);
      @(negedge clk);
      check_eq("t5_wrap", vec_count, 8'd0);

      // 6: in_last handling
      apply_reset();
      out_ready = 1'b1;
      push(32'h3F800000, 32'h40000000, 1'b0);
      push(32'h40400000, 32'h40800000, 1'b1);
`ifdef VEC_PAD_EN
      check_eq("t6_pad_valid", out_valid, 1'b1);
      check_eq("t6_pad_a", out_a, 128'h00000000_00000000_40400000_3F800000);
      check_eq("t6_pad_b", out_b, 128'h00000000_00000000_40800000_40000000);
`else
      check_eq("t6_no_vector", out_valid, 1'b0);
      push(32'h40A00000, 32'h0, 1'b1);
      check_eq("t6_still_no_vector", out_valid, 1'b0);
      push(32'h40C00000, 32'h0, 1'b0);
      exp_v = 128'h40C00000_40A00000_40400000_3F800000;
      check_eq("t6_full_valid", out_valid, 1'b1);
      check_eq("t6_full_a", out_a, exp_v);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_applied, miscompares);
      $finish;
   end

endmodule
